// File: rtl/mem_responder.sv
// Purpose: single-outstanding load/store responder backed by a word-addressed RAM.
// Latency: request seen in cycle 0 gets its response pulse in cycle LATENCY+1, and one access completes every LATENCY+2 cycles.
// Backpressure: the core holds rden/wren until memory_response. No new request is accepted until the FSM is back in IDLE.
//
// Ports:
//   clk, reset           - clock; asynchronous active-low reset
//   memory_addr          - byte address; word index = memory_addr[ADDR_WIDTH+1:2]
//   memory_rden/_wren    - level request strobes, sampled only in IDLE
//   memory_write_val     - store data, captured when the request is accepted
//   memory_read_val      - load data, updated on entry to RESP and held afterwards
//   memory_response      - one-cycle completion pulse
//   busy                 - high while an access is in WAIT or RESP
//   memory_error         - present only with MEM_ERR_CHECK_EN. Pulses with the response
//                          when the address is misaligned or out of range.
// Optional feature macro: MEM_ERR_CHECK_EN
module mem_responder #(
    parameter int    ADDR_WIDTH = 10,
    parameter int    LATENCY    = 2,
    parameter string INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] memory_addr,
    input  logic        memory_rden,
    input  logic        memory_wren,
    input  logic [31:0] memory_write_val,
    output logic [31:0] memory_read_val,
    output logic        memory_response,
`ifdef MEM_ERR_CHECK_EN
    output logic        memory_error,
`endif
    output logic        busy
);

    localparam int         DEPTH  = 2 ** ADDR_WIDTH;
    localparam logic [3:0] LAT_M1 = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [3:0]            wait_cnt;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic                  rd_q, wr_q, err_q;
    logic [31:0]           wdata_q;
    logic [31:0]           ram [0:DEPTH-1];

    logic                  req, accept, commit;
    logic                  addr_hi_set, acc_err;
    logic                  eff_rd, eff_wr, eff_err;
    logic [ADDR_WIDTH-1:0] eff_idx;
    logic [31:0]           eff_wdata;

    // Address bits above the RAM index only exist when ADDR_WIDTH < 30.
    if (ADDR_WIDTH < 30) begin : g_hi
        assign addr_hi_set = |memory_addr[31:ADDR_WIDTH+2];
    end else begin : g_nohi
        assign addr_hi_set = 1'b0;
    end

`ifdef MEM_ERR_CHECK_EN
    assign acc_err = (memory_addr[1:0] != 2'b00) || addr_hi_set;
`else
    // Low and high address bits are deliberately ignored, so addresses alias.
    assign acc_err = 1'b0;
    logic unused_addr_bits;
    assign unused_addr_bits = ^{memory_addr[1:0], addr_hi_set};
`endif

    assign req    = memory_rden | memory_wren;
    assign accept = (state == IDLE) && req;

    // With LATENCY=0 the RAM access happens on the accepting edge itself, so the
    // live inputs are used in IDLE. Otherwise the registered copy is used.
    always_comb begin
        if (state == IDLE) begin
            eff_rd    = memory_rden;
            eff_wr    = memory_wren;
            eff_err   = acc_err;
            eff_idx   = memory_addr[ADDR_WIDTH+1:2];
            eff_wdata = memory_write_val;
        end else begin
            eff_rd    = rd_q;
            eff_wr    = wr_q;
            eff_err   = err_q;
            eff_idx   = idx_q;
            eff_wdata = wdata_q;
        end
    end

    // The access commits on the edge that enters RESP. A reset that is still
    // asserted blocks the commit, so an aborted write never reaches the RAM.
    assign commit = reset && (state_nxt == RESP);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = (LATENCY > 0) ? WAIT : RESP;
            WAIT:    if (wait_cnt == 4'd0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        memory_response = (state == RESP);
        busy            = (state != IDLE);
    end

`ifdef MEM_ERR_CHECK_EN
    assign memory_error = (state == RESP) && err_q;
`endif

    // Wait-state counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= 4'd0;
        end else if (accept) begin
            wait_cnt <= LAT_M1;
        end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // Registered request copy. The core may drop or change its inputs during WAIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q   <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
        end else if (accept) begin
            idx_q   <= memory_addr[ADDR_WIDTH+1:2];
            rd_q    <= memory_rden;
            wr_q    <= memory_wren;
            err_q   <= acc_err;
            wdata_q <= memory_write_val;
        end
    end

    // Load data. A combined rd+wr returns the pre-write word because the RAM
    // write below lands on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            memory_read_val <= '0;
        end else if (commit && eff_rd) begin
            memory_read_val <= eff_err ? 32'hDEADBEEF : ram[eff_idx];
        end
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (commit && eff_wr && !eff_err) ram[eff_idx] <= eff_wdata;
    end

endmodule
